// File: rtl/rsa_exp_sched.sv
// Round-robin scheduler that shares one modular-exponentiation engine between
// N_REQ requesters, screens trivial jobs, and bounds each engine run with a watchdog.
module rsa_exp_sched #(
  parameter int          W       = 2048,
  parameter int          N_REQ   = 2,
  parameter int          IDW     = 3,
  parameter logic [31:0] TIMEOUT = 32'd16777215
) (
  input  logic               clk,
  input  logic               sys_rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*W-1:0] req_c,
  input  logic [N_REQ*W-1:0] req_e,
  input  logic [N_REQ*W-1:0] req_n,
  output logic               rsp_valid,
  output logic [IDW-1:0]     rsp_id,
  output logic [W-1:0]       rsp_data,
  output logic [1:0]         rsp_err,
  output logic               busy,
  output logic               eng_rst,
  output logic [W-1:0]       eng_c,
  output logic [W-1:0]       eng_e,
  output logic [W-1:0]       eng_n,
  input  logic               eng_finish,
  input  logic [W-1:0]       eng_result
);

  localparam int SW = IDW + 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LAUNCH   = 3'd1,
    WAIT_ENG = 3'd2,
    RESP     = 3'd3
  } state_t;

  state_t             state;
  logic [IDW-1:0]     rr_ptr;
  logic [IDW-1:0]     job_id;
  logic [31:0]        wdog;
  logic               armed;

  logic [W-1:0]       c_arr [N_REQ];
  logic [W-1:0]       e_arr [N_REQ];
  logic [W-1:0]       n_arr [N_REQ];

  logic [2*N_REQ-1:0] valid_dbl;
  logic [N_REQ-1:0]   valid_rot;
  logic [SW-1:0]      idx_sum;
  logic               grant_any;
  logic [IDW-1:0]     grant_idx;
  logic [N_REQ-1:0]   grant_onehot;
  logic [IDW-1:0]     rr_next;
  logic [W-1:0]       sel_c;
  logic [W-1:0]       sel_e;
  logic [W-1:0]       sel_n;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign c_arr[gi] = req_c[gi*W +: W];
      assign e_arr[gi] = req_e[gi*W +: W];
      assign n_arr[gi] = req_n[gi*W +: W];
    end
  endgenerate

  // Rotate the request vector so bit 0 is the requester at rr_ptr; the lowest
  // set bit of the rotated vector is the winner.
  always_comb begin
    valid_dbl = {req_valid, req_valid};
    valid_rot = N_REQ'(valid_dbl >> rr_ptr);
    grant_any = |valid_rot;
    grant_idx = '0;
    idx_sum   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (valid_rot[i]) begin
        idx_sum = {1'b0, rr_ptr} + SW'(i);
        if (idx_sum >= SW'(N_REQ)) begin
          idx_sum = idx_sum - SW'(N_REQ);
        end
        grant_idx = idx_sum[IDW-1:0];
      end
    end
  end

  always_comb begin
    sel_c        = c_arr[0];
    sel_e        = e_arr[0];
    sel_n        = n_arr[0];
    grant_onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        sel_c = c_arr[i];
        sel_e = e_arr[i];
        sel_n = n_arr[i];
        grant_onehot[i] = grant_any;
      end
    end
  end

  assign rr_next   = (grant_idx == IDW'(N_REQ - 1)) ? '0 : grant_idx + IDW'(1);
  assign req_ready = (armed && state == IDLE) ? grant_onehot : '0;

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      job_id    <= '0;
      wdog      <= '0;
      armed     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_err   <= 2'b00;
      busy      <= 1'b0;
      eng_rst   <= 1'b1;
      eng_c     <= '0;
      eng_e     <= '0;
      eng_n     <= '0;
    end else begin
      armed     <= 1'b1;
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          eng_rst <= 1'b1;
          if (armed && grant_any) begin
            eng_c  <= sel_c;
            eng_e  <= sel_e;
            eng_n  <= sel_n;
            job_id <= grant_idx;
            rr_ptr <= rr_next;
            busy   <= 1'b1;
            // Screening looks at the raw slice, not the just-latched copy.
            if (!sel_n[0]) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_id    <= grant_idx;
              rsp_data  <= '0;
              rsp_err   <= 2'b01;
            end else if (sel_e == '0) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_id    <= grant_idx;
              rsp_data  <= (sel_n == W'(1)) ? '0 : W'(1);
              rsp_err   <= 2'b00;
            end else begin
              state <= LAUNCH;
            end
          end
        end
        LAUNCH: begin
          state   <= WAIT_ENG;
          wdog    <= '0;
          eng_rst <= 1'b0;
        end
        WAIT_ENG: begin
          wdog <= wdog + 32'd1;
          if (eng_finish) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_id    <= job_id;
            rsp_data  <= eng_result;
            rsp_err   <= 2'b00;
            eng_rst   <= 1'b1;
          end else if (wdog == TIMEOUT - 32'd1) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_id    <= job_id;
            rsp_data  <= '0;
            rsp_err   <= 2'b10;
            eng_rst   <= 1'b1;
          end
        end
        RESP: begin
          state   <= IDLE;
          busy    <= 1'b0;
          eng_rst <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          eng_rst <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_exp_sched.sv
// Bench for rsa_exp_sched: a job-level scoreboard predicts grant order, response
// timing and results; a second instance with a short watchdog covers timeouts.
module tb_rsa_exp_sched;
  localparam int W      = 16;
  localparam int N      = 2;
  localparam int IDW    = 3;
  localparam int D_MAIN = 20;

  typedef struct packed {
    logic [W-1:0] c;
    logic [W-1:0] e;
    logic [W-1:0] n;
  } job_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic sys_rst_n;

  logic [N-1:0]   req_valid, req_ready;
  logic [N*W-1:0] req_c, req_e, req_n;
  logic           rsp_valid, busy, eng_rst, eng_finish;
  logic [IDW-1:0] rsp_id;
  logic [W-1:0]   rsp_data, eng_c, eng_e, eng_n, eng_result;
  logic [1:0]     rsp_err;

  logic [N-1:0]   req_valid_b, req_ready_b;
  logic [N*W-1:0] req_c_b, req_e_b, req_n_b;
  logic           rsp_valid_b, busy_b, eng_rst_b, eng_finish_b;
  logic [IDW-1:0] rsp_id_b;
  logic [W-1:0]   rsp_data_b, eng_c_b, eng_e_b, eng_n_b, eng_result_b;
  logic [1:0]     rsp_err_b;

  rsa_exp_sched #(.W(W), .N_REQ(N), .IDW(IDW)) dut (
    .clk(clk), .sys_rst_n(sys_rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_c(req_c), .req_e(req_e), .req_n(req_n), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy), .eng_rst(eng_rst),
    .eng_c(eng_c), .eng_e(eng_e), .eng_n(eng_n), .eng_finish(eng_finish), .eng_result(eng_result)
  );

  rsa_exp_sched #(.W(W), .N_REQ(N), .IDW(IDW), .TIMEOUT(32'd10)) dut_b (
    .clk(clk), .sys_rst_n(sys_rst_n), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_c(req_c_b), .req_e(req_e_b), .req_n(req_n_b), .rsp_valid(rsp_valid_b), .rsp_id(rsp_id_b),
    .rsp_data(rsp_data_b), .rsp_err(rsp_err_b), .busy(busy_b), .eng_rst(eng_rst_b),
    .eng_c(eng_c_b), .eng_e(eng_e_b), .eng_n(eng_n_b), .eng_finish(eng_finish_b), .eng_result(eng_result_b)
  );

  function automatic logic [W-1:0] modexp(input logic [W-1:0] c, input logic [W-1:0] e, input logic [W-1:0] n);
    longint unsigned r, b, m;
    if (n == '0) return '0;
    m = longint'(n);
    r = 1 % m;
    b = longint'(c) % m;
    for (int i = 0; i < W; i++) begin
      if (e[i]) r = (r * b) % m;
      b = (b * b) % m;
    end
    return W'(r);
  endfunction

  // Engine stubs: finish rises a fixed number of cycles after eng_rst falls.
  int cnt_a, cnt_b, d_b;
  always @(posedge clk) cnt_a <= eng_rst ? 0 : cnt_a + 1;
  always @(posedge clk) cnt_b <= eng_rst_b ? 0 : cnt_b + 1;
  assign eng_finish   = !eng_rst && (cnt_a >= D_MAIN);
  assign eng_result   = modexp(eng_c, eng_e, eng_n);
  assign eng_finish_b = !eng_rst_b && (cnt_b >= d_b);
  assign eng_result_b = modexp(eng_c_b, eng_e_b, eng_n_b);

  int total = 0, bad = 0, cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  job_t q0[$], q1[$];

  int           m_rr = 0, m_g = 0, m_tg = -100, m_trsp = -100, m_free_at = 0;
  bit           m_eng = 0;
  job_t         m_job;
  logic [W-1:0] m_data;
  logic [1:0]   m_err;
  int           l_id = 0;
  logic [W-1:0] l_data = '0;
  logic [1:0]   l_err = 2'b00;

  int           g_cyc, f_cyc, r_cyc;
  int           lg_id[$];
  logic [W-1:0] lg_data[$];
  logic [1:0]   lg_err[$];

  task automatic new_phase();
    g_cyc = -1; f_cyc = -1; r_cyc = -1;
    lg_id.delete(); lg_data.delete(); lg_err.delete();
  endtask

  task automatic load_drive();
    req_valid = '0;
    if (q0.size() > 0) begin
      req_valid[0] = 1'b1; req_c[0 +: W] = q0[0].c; req_e[0 +: W] = q0[0].e; req_n[0 +: W] = q0[0].n;
    end
    if (q1.size() > 0) begin
      req_valid[1] = 1'b1; req_c[W +: W] = q1[0].c; req_e[W +: W] = q1[0].e; req_n[W +: W] = q1[0].n;
    end
  endtask

  // Outcome of a job from the screening rules alone.
  task automatic expect_job(input job_t j, output logic [W-1:0] d, output logic [1:0] er, output bit eng);
    if (!j.n[0]) begin
      d = '0; er = 2'b01; eng = 0;
    end else if (j.e == '0) begin
      d = (j.n == W'(1)) ? W'(0) : W'(1); er = 2'b00; eng = 0;
    end else begin
      d = modexp(j.c, j.e, j.n); er = 2'b00; eng = 1;
    end
  endtask

  task automatic check();
    logic [N-1:0] exp_ready;
    bit in_job, er_exp;
    int g;
    cyc++;
    exp_ready = '0;
    if (cyc >= m_free_at && (q0.size() > 0 || q1.size() > 0)) begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_rr + k) % N;
        if (g < 0 && ((idx == 0 && q0.size() > 0) || (idx == 1 && q1.size() > 0))) g = idx;
      end
      if (g == 0) m_job = q0.pop_front();
      else        m_job = q1.pop_front();
      exp_ready[g] = 1'b1;
      m_rr = (g + 1) % N;
      m_g  = g;
      m_tg = cyc;
      expect_job(m_job, m_data, m_err, m_eng);
      m_trsp    = m_eng ? cyc + 3 + D_MAIN : cyc + 1;
      m_free_at = m_trsp + 1;
    end
    in_job = (cyc > m_tg) && (cyc <= m_trsp);
    chk("req_ready", req_ready, exp_ready);
    chk("busy", busy, in_job);
    chk("rsp_valid", rsp_valid, cyc == m_trsp);
    if (cyc == m_trsp) begin
      l_id = m_g; l_data = m_data; l_err = m_err;
    end
    chk("rsp_id", rsp_id, l_id);
    chk("rsp_data", rsp_data, l_data);
    chk("rsp_err", rsp_err, l_err);
    er_exp = !(m_eng && in_job && cyc >= m_tg + 2 && cyc < m_trsp);
    chk("eng_rst", eng_rst, er_exp);
    if (in_job) begin
      chk("eng_c", eng_c, m_job.c);
      chk("eng_e", eng_e, m_job.e);
      chk("eng_n", eng_n, m_job.n);
    end
    if (req_ready != '0 && g_cyc < 0) g_cyc = cyc;
    if (!eng_rst && f_cyc < 0) f_cyc = cyc;
    if (rsp_valid) begin
      if (r_cyc < 0) r_cyc = cyc;
      lg_id.push_back(int'(rsp_id));
      lg_data.push_back(rsp_data);
      lg_err.push_back(rsp_err);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    load_drive();
    @(negedge clk);
    check();
  endtask

  task automatic run_jobs(input int budget);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || cyc < m_free_at) && n < budget) begin
      step();
      n++;
    end
    chk("run_budget", n < budget, 1);
    step();
  endtask

  task automatic push(input int r, input int c, input int e, input int n);
    job_t j;
    j.c = W'(c); j.e = W'(e); j.n = W'(n);
    if (r == 0) q0.push_back(j);
    else        q1.push_back(j);
  endtask

  task automatic run_b(input int dly, input logic [1:0] want_err, input logic [W-1:0] want_data);
    int fcyc, rcyc;
    bit got;
    d_b = dly;
    @(posedge clk); #1;
    req_valid_b = 2'b01; req_c_b = '0; req_e_b = '0; req_n_b = '0;
    req_c_b[0 +: W] = W'(5); req_e_b[0 +: W] = W'(3); req_n_b[0 +: W] = W'(13);
    fcyc = -1; rcyc = -1; got = 0;
    for (int c = 0; c < 60 && rcyc < 0; c++) begin
      @(negedge clk);
      if (req_ready_b[0]) got = 1;
      if (fcyc < 0 && !eng_rst_b) fcyc = c;
      if (rsp_valid_b) begin
        rcyc = c;
        chk("b_err", rsp_err_b, want_err);
        chk("b_data", rsp_data_b, want_data);
        chk("b_id", rsp_id_b, 0);
        chk("b_rst_at_resp", eng_rst_b, 1);
      end
      @(posedge clk); #1;
      if (got) req_valid_b = '0;
    end
    chk("b_rsp_seen", rcyc >= 0, 1);
    chk("b_latency", rcyc - fcyc, 10);
    @(negedge clk);
    chk("b_pulse", rsp_valid_b, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    sys_rst_n = 1'b0;
    req_valid = 2'b11; req_c = '0; req_e = '0; req_n = '0;
    req_valid_b = '0; req_c_b = '0; req_e_b = '0; req_n_b = '0;
    d_b = 1000;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_eng_rst", eng_rst, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_eng_c", eng_c, 0);
    req_valid = '0;
    #2 sys_rst_n = 1'b1;

    // Engine job: 5^3 mod 13 = 8.
    new_phase();
    push(0, 5, 3, 13);
    run_jobs(100);
    chk("p1_count", lg_id.size(), 1);
    chk("p1_data", lg_data[0], 8);
    chk("p1_id", lg_id[0], 0);
    chk("p1_rst_high", f_cyc - g_cyc, 2);
    chk("p1_rsp_lat", r_cyc - f_cyc, 21);

    // Trivial exponents on requester 1.
    new_phase();
    push(1, 7, 0, 13);
    push(1, 7, 0, 1);
    run_jobs(50);
    chk("p2_data0", lg_data[0], 1);
    chk("p2_data1", lg_data[1], 0);
    chk("p2_no_launch", f_cyc, -1);
    chk("p2_lat", r_cyc - g_cyc, 1);

    // Both requesters loaded: strict alternation 0,1,0,1,...
    new_phase();
    push(0, 3, 7, 11); push(0, 2, 0, 9);  push(0, 4, 5, 16); push(0, 6, 2, 7);
    push(1, 9, 3, 23); push(1, 5, 0, 1);  push(1, 12, 1, 17); push(1, 1, 1, 3);
    run_jobs(400);
    chk("p4_count", lg_id.size(), 8);
    for (int i = 0; i < 8 && i < lg_id.size(); i++) chk("p4_order", lg_id[i], i % 2);
    chk("p4_data0", lg_data[0], 9);
    chk("p4_data1", lg_data[1], 16);

    // Even modulus rejected, then e=4 mod 15.
    new_phase();
    push(0, 3, 5, 14);
    push(0, 2, 4, 15);
    run_jobs(100);
    chk("p3_err0", lg_err[0], 1);
    chk("p3_data0", lg_data[0], 0);
    chk("p3_data1", lg_data[1], 1);
    chk("p3_err1", lg_err[1], 0);

    // Reset in the middle of an engine run.
    new_phase();
    push(0, 5, 3, 13);
    for (int n = 0; n < 40 && !(m_eng && cyc == m_tg + 8); n++) step();
    chk("p5_in_wait", eng_rst, 0);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("ar_req_ready", req_ready, 0);
    chk("ar_rsp_valid", rsp_valid, 0);
    chk("ar_rsp_id", rsp_id, 0);
    chk("ar_rsp_data", rsp_data, 0);
    chk("ar_rsp_err", rsp_err, 0);
    chk("ar_busy", busy, 0);
    chk("ar_eng_rst", eng_rst, 1);
    chk("ar_eng_c", eng_c, 0);
    chk("ar_eng_e", eng_e, 0);
    chk("ar_eng_n", eng_n, 0);
    @(negedge clk);
    chk("ar_hold_valid", rsp_valid, 0);
    chk("ar_hold_rst", eng_rst, 1);
    #2 sys_rst_n = 1'b1;
    m_rr = 0; m_tg = -100; m_trsp = -100; m_free_at = cyc + 1; m_eng = 0;
    l_id = 0; l_data = '0; l_err = 2'b00;
    push(0, 2, 3, 7);
    push(1, 3, 3, 7);
    run_jobs(150);
    chk("p5_count", lg_id.size(), 2);
    chk("p5_first_id", lg_id[0], 0);
    chk("p5_data0", lg_data[0], 1);
    chk("p5_data1", lg_data[1], 6);

    // Short watchdog instance: never finishes, finishes on the last allowed cycle, one cycle late.
    run_b(1000, 2'b10, 0);
    run_b(9, 2'b00, 8);
    run_b(10, 2'b10, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
